// File: rtl/store_narrow_unit.sv
// Store-side narrowing unit: places sb/sh/sw data into the correct byte lane of a
// word-only synchronous RAM, using read-modify-write for sub-word stores.
module store_narrow_unit #(
   parameter int ADDR_WIDTH = 32,
   parameter int BIG_ENDIAN = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [1:0]            req_size,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [31:0]           req_data,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic                  mem_rd_en,
   input  logic [31:0]           mem_rd_data,
   output logic                  mem_wr_en,
   output logic [31:0]           mem_wr_data,
   output logic                  done,
   output logic                  misaligned
);

   localparam logic [1:0] SIZE_BYTE = 2'b00;
   localparam logic [1:0] SIZE_HALF = 2'b01;
   localparam logic [1:0] SIZE_WORD = 2'b10;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_READ  = 3'd1,
      ST_WAIT  = 3'd2,
      ST_WRITE = 3'd3,
      ST_ERR   = 3'd4
   } state_t;

   state_t                  state_r;
   state_t                  state_next_s;
   logic                    accept_s;
   logic [1:0]              off_s;
   logic [4:0]              shift_s;
   logic [31:0]             base_mask_s;
   logic [31:0]             lane_mask_s;
   logic [31:0]             lane_data_s;
   logic [31:0]             lane_mask_r;
   logic [31:0]             lane_data_r;
   logic [ADDR_WIDTH-1:0]   mem_addr_r;
   logic [31:0]             wr_data_r;
   logic                    rd_en_s;
   logic                    wr_en_s;
   logic                    done_s;
   logic                    mis_s;
   logic                    rd_en_r;
   logic                    wr_en_r;
   logic                    done_r;
   logic                    mis_r;

   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
      logic bad;
      case (size)
         SIZE_BYTE: bad = 1'b0;
         SIZE_HALF: bad = off[0];
         SIZE_WORD: bad = (off != 2'b00);
         default:   bad = 1'b1;
      endcase
      return bad;
   endfunction

   // Lane index counts byte positions from bit 0; big-endian numbers offsets from the MSB.
   function automatic logic [4:0] lane_shift(input logic [1:0] size, input logic [1:0] off);
      logic [1:0] lane;
      if (BIG_ENDIAN != 0) begin
         if (size == SIZE_HALF) begin
            lane = 2'd2 - off;
         end else begin
            lane = 2'd3 - off;
         end
      end else begin
         lane = off;
      end
      return {lane, 3'b000};
   endfunction

   assign req_ready = rst_n && (state_r == ST_IDLE);
   assign accept_s  = req_valid && req_ready;

   // Lane mask and positioned store data for the incoming request.
   always_comb begin
      off_s   = req_addr[1:0];
      shift_s = lane_shift(req_size, off_s);
      if (req_size == SIZE_HALF) begin
         base_mask_s = 32'h0000_FFFF;
      end else begin
         base_mask_s = 32'h0000_00FF;
      end
      lane_mask_s = base_mask_s << shift_s;
      lane_data_s = (req_data & base_mask_s) << shift_s;
   end

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Next-state logic.
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (accept_s) begin
               if (is_misaligned(req_size, req_addr[1:0])) begin
                  state_next_s = ST_ERR;
               end else if (req_size == SIZE_WORD) begin
                  state_next_s = ST_WRITE;
               end else begin
                  state_next_s = ST_READ;
               end
            end else begin
               state_next_s = ST_IDLE;
            end
         end
         ST_READ:  state_next_s = ST_WAIT;
         ST_WAIT:  state_next_s = ST_WRITE;
         ST_WRITE: state_next_s = ST_IDLE;
         ST_ERR:   state_next_s = ST_IDLE;
         default:  state_next_s = ST_IDLE;
      endcase
   end

   // Strobes decoded from the next state so they can be registered without adding latency.
   always_comb begin
      rd_en_s = 1'b0;
      wr_en_s = 1'b0;
      done_s  = 1'b0;
      mis_s   = 1'b0;
      case (state_next_s)
         ST_READ:  rd_en_s = 1'b1;
         ST_WRITE: begin
            wr_en_s = 1'b1;
            done_s  = 1'b1;
         end
         ST_ERR: begin
            done_s = 1'b1;
            mis_s  = 1'b1;
         end
         default: rd_en_s = 1'b0;
      endcase
   end

   // Output strobe registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rd_en_r <= 1'b0;
         wr_en_r <= 1'b0;
         done_r  <= 1'b0;
         mis_r   <= 1'b0;
      end else begin
         rd_en_r <= rd_en_s;
         wr_en_r <= wr_en_s;
         done_r  <= done_s;
         mis_r   <= mis_s;
      end
   end

   // Request latch and merge register; a word store loads the merge register directly.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         mem_addr_r  <= {ADDR_WIDTH{1'b0}};
         wr_data_r   <= 32'h0000_0000;
         lane_mask_r <= 32'h0000_0000;
         lane_data_r <= 32'h0000_0000;
      end else if (accept_s) begin
         mem_addr_r  <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
         lane_mask_r <= lane_mask_s;
         lane_data_r <= lane_data_s;
         if (req_size == SIZE_WORD) begin
            wr_data_r <= req_data;
         end
      end else if (state_r == ST_WAIT) begin
         wr_data_r <= (mem_rd_data & ~lane_mask_r) | lane_data_r;
      end
   end

   assign mem_addr    = mem_addr_r;
   assign mem_rd_en   = rd_en_r;
   assign mem_wr_en   = wr_en_r;
   assign mem_wr_data = wr_data_r;
   assign done        = done_r;
   assign misaligned  = mis_r;

endmodule

// File: tb/tb_store_narrow_unit.sv
// Bench for store_narrow_unit: big- and little-endian instances share stimulus; a
// byte-addressed reference model feeds a scoreboard checked by a negedge monitor.
module tb_store_narrow_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid;
   logic [1:0]  req_size;
   logic [31:0] req_addr;
   logic [31:0] req_data;

   logic        ready  [2];
   logic        rd_en  [2];
   logic        wr_en  [2];
   logic        done_o [2];
   logic        mis    [2];
   logic [31:0] maddr  [2];
   logic [31:0] wdata  [2];
   logic [31:0] rdata  [2];

   logic [31:0] ram   [2][256];
   logic [31:0] model [2][256];

   logic        pl_en;
   logic [7:0]  pl_idx;
   logic [31:0] pl_val;

   int cyc  = 0;
   int nchk = 0;
   int nerr = 0;
   int rdcnt [2];
   int last_acc;

   typedef struct {
      bit          mis;
      logic [31:0] addr;
      logic [31:0] data_be;
      logic [31:0] data_le;
      int          acc;
      int          lat;
      int          rds;
   } exp_t;

   exp_t sbq[$];

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   store_narrow_unit #(.ADDR_WIDTH(32), .BIG_ENDIAN(1)) u_be (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(ready[0]),
      .req_size(req_size), .req_addr(req_addr), .req_data(req_data),
      .mem_addr(maddr[0]), .mem_rd_en(rd_en[0]), .mem_rd_data(rdata[0]),
      .mem_wr_en(wr_en[0]), .mem_wr_data(wdata[0]), .done(done_o[0]), .misaligned(mis[0])
   );

   store_narrow_unit #(.ADDR_WIDTH(32), .BIG_ENDIAN(0)) u_le (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(ready[1]),
      .req_size(req_size), .req_addr(req_addr), .req_data(req_data),
      .mem_addr(maddr[1]), .mem_rd_en(rd_en[1]), .mem_rd_data(rdata[1]),
      .mem_wr_en(wr_en[1]), .mem_wr_data(wdata[1]), .done(done_o[1]), .misaligned(mis[1])
   );

   // Synchronous RAMs (one per instance) with a bench preload port.
   always @(posedge clk) begin
      if (pl_en) begin
         ram[0][pl_idx] <= pl_val;
         ram[1][pl_idx] <= pl_val;
      end else begin
         for (int d = 0; d < 2; d++) begin
            if (rd_en[d]) rdata[d] <= ram[d][maddr[d][9:2]];
            if (wr_en[d]) ram[d][maddr[d][9:2]] <= wdata[d];
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Memory semantics: byte address p within a word holds bits [31-8p -: 8] (BE) or [8p +: 8] (LE);
   // the most significant stored byte goes to the lowest address on big-endian.
   function automatic logic [31:0] model_store(input logic [31:0] old, input logic [1:0] sz,
                                               input logic [1:0] off, input logic [31:0] d, input bit be);
      int nb;
      int p;
      int q;
      logic [31:0] r;
      nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
      r  = old;
      for (int i = 0; i < nb; i++) begin
         p = int'(off) + i;
         q = be ? 3 - p : p;
         r[8*q +: 8] = be ? d[8*(nb-1-i) +: 8] : d[8*i +: 8];
      end
      return r;
   endfunction

   // Scoreboard monitor.
   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         rdcnt[0] <= 0;
         rdcnt[1] <= 0;
      end else begin
         for (int d = 0; d < 2; d++) begin
            if (rd_en[d] || wr_en[d]) chk("strobe_exclusive", {31'd0, rd_en[d] & wr_en[d]}, 32'd0);
            if (rd_en[d]) rdcnt[d] <= rdcnt[d] + 1;
         end
         if (done_o[0] || done_o[1]) begin
            chk("done_lockstep", {31'd0, done_o[1]}, {31'd0, done_o[0]});
            if (sbq.size() == 0) begin
               chk("unexpected_done", 32'd1, 32'd0);
            end else begin
               e = sbq.pop_front();
               chk("latency", 32'(cyc - e.acc), 32'(e.lat));
               for (int d = 0; d < 2; d++) begin
                  chk("misaligned", {31'd0, mis[d]}, {31'd0, e.mis});
                  chk("wr_en", {31'd0, wr_en[d]}, {31'd0, !e.mis});
                  chk("read_count", 32'(rdcnt[d]), 32'(e.rds));
                  if (!e.mis) begin
                     chk("mem_addr", maddr[d], e.addr);
                     chk(d == 0 ? "wr_data_be" : "wr_data_le", wdata[d], d == 0 ? e.data_be : e.data_le);
                  end
               end
            end
            rdcnt[0] <= 0;
            rdcnt[1] <= 0;
         end else if (wr_en[0] || wr_en[1]) begin
            chk("stray_write", 32'd1, 32'd0);
         end
      end
   end

   task automatic preload(input int idx, input logic [31:0] val);
      pl_en  = 1'b1;
      pl_idx = 8'(idx);
      pl_val = val;
      @(negedge clk);
      pl_en = 1'b0;
      model[0][idx] = val;
      model[1][idx] = val;
   endtask

   // Called at a negedge; returns at the negedge following the accept edge with req_valid still high.
   task automatic issue(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d, output int waited);
      exp_t e;
      int   idx;
      int   nb;
      req_size  = sz;
      req_addr  = a;
      req_data  = d;
      req_valid = 1'b1;
      waited    = 0;
      while (!ready[0] && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      if (!ready[0]) begin
         chk("accept_timeout", 32'd0, 32'd1);
         req_valid = 1'b0;
      end else begin
         chk("ready_lockstep", {31'd0, ready[1]}, {31'd0, ready[0]});
         idx       = int'(a[9:2]);
         nb        = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
         e.mis     = (sz == 2'd3) || ((a % nb) != 0);
         e.addr    = {a[31:2], 2'b00};
         e.acc     = cyc;
         e.lat     = (!e.mis && sz != 2'd2) ? 3 : 1;
         e.rds     = (!e.mis && sz != 2'd2) ? 1 : 0;
         e.data_be = model_store(model[0][idx], sz, a[1:0], d, 1'b1);
         e.data_le = model_store(model[1][idx], sz, a[1:0], d, 1'b0);
         if (!e.mis) begin
            model[0][idx] = e.data_be;
            model[1][idx] = e.data_le;
         end
         sbq.push_back(e);
         last_acc = e.acc;
         @(negedge clk);
      end
   endtask

   task automatic idle(input int n);
      req_valid = 1'b0;
      for (int i = 0; i < n; i++) begin
         req_addr = $urandom;
         req_data = $urandom;
         req_size = 2'($urandom_range(0, 3));
         @(negedge clk);
      end
   endtask

   task automatic chk_reset_outputs(input logic rdy);
      for (int d = 0; d < 2; d++) begin
         chk("rst_ready", {31'd0, ready[d]}, {31'd0, rdy});
         chk("rst_rd_en", {31'd0, rd_en[d]}, 32'd0);
         chk("rst_wr_en", {31'd0, wr_en[d]}, 32'd0);
         chk("rst_done", {31'd0, done_o[d]}, 32'd0);
         chk("rst_misaligned", {31'd0, mis[d]}, 32'd0);
         chk("rst_mem_addr", maddr[d], 32'd0);
         chk("rst_wr_data", wdata[d], 32'd0);
      end
   endtask

   initial begin
      int w;
      int acc1;
      int bad;
      logic [1:0] sz;
      rst_n     = 1'b0;
      req_valid = 1'b0;
      req_size  = 2'd0;
      req_addr  = 32'd0;
      req_data  = 32'd0;
      pl_en     = 1'b0;
      pl_idx    = 8'd0;
      pl_val    = 32'd0;
      @(negedge clk);
      for (int i = 0; i < 256; i++) preload(i, $urandom);
      chk_reset_outputs(1'b0);
      preload(64, 32'h1122_3344);
      rst_n = 1'b1;
      @(negedge clk);
      chk("ready_after_reset", {31'd0, ready[0]}, 32'd1);

      // sb / sh / sw on the reference word
      issue(2'd0, 32'h101, 32'hFFFF_FFAB, w);
      idle(4);
      chk("sb_be_word", ram[0][64], 32'h11AB_3344);
      chk("sb_le_word", ram[1][64], 32'h1122_AB44);
      preload(64, 32'h1122_3344);
      issue(2'd1, 32'h102, 32'h0000_BEEF, w);
      idle(4);
      chk("sh_be_word", ram[0][64], 32'h1122_BEEF);
      chk("sh_le_word", ram[1][64], 32'hBEEF_3344);
      issue(2'd2, 32'h104, 32'hDEAD_BEEF, w);
      idle(3);
      chk("sw_be_word", ram[0][65], 32'hDEAD_BEEF);
      chk("sw_le_word", ram[1][65], 32'hDEAD_BEEF);

      // misaligned requests leave memory untouched
      issue(2'd1, 32'h103, 32'h1234_5678, w);
      idle(2);
      issue(2'd2, 32'h106, 32'h1234_5678, w);
      idle(2);
      issue(2'd3, 32'h100, 32'h1234_5678, w);
      idle(3);
      chk("mis_word64_be", ram[0][64], 32'h1122_BEEF);
      chk("mis_word65_le", ram[1][65], 32'hDEAD_BEEF);

      // back-to-back with req_valid held high
      issue(2'd0, 32'h100, 32'h0000_0055, w);
      acc1 = last_acc;
      issue(2'd2, 32'h200, 32'hCAFE_F00D, w);
      chk("b2b_ready_low_cycles", 32'(w), 32'd3);
      chk("b2b_accept_gap", 32'(last_acc - acc1), 32'd4);
      idle(3);
      chk("b2b_second_write", ram[0][128], 32'hCAFE_F00D);

      // reset during WAIT abandons the store
      preload(64, 32'h1122_3344);
      issue(2'd0, 32'h101, 32'hFFFF_FFAB, w);
      req_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      sbq.delete();
      model[0][64] = 32'h1122_3344;
      model[1][64] = 32'h1122_3344;
      @(negedge clk);
      chk_reset_outputs(1'b0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("ready_after_abort", {31'd0, ready[0]}, 32'd1);
      idle(4);
      chk("abort_no_write", ram[0][64], 32'h1122_3344);

      // randomized traffic
      for (int n = 0; n < 200; n++) begin
         w  = $urandom_range(0, 9);
         sz = (w < 3) ? 2'd0 : (w < 6) ? 2'd1 : (w < 9) ? 2'd2 : 2'd3;
         issue(sz, 32'($urandom_range(0, 1023)), $urandom, w);
         if ($urandom_range(0, 1) == 0) idle($urandom_range(0, 2));
      end
      idle(1);
      w = 0;
      while (sbq.size() != 0 && w < 20) begin
         @(negedge clk);
         w++;
      end
      chk("drain_pending", 32'(sbq.size()), 32'd0);

      for (int d = 0; d < 2; d++) begin
         bad = 0;
         for (int i = 0; i < 256; i++) if (ram[d][i] !== model[d][i]) bad++;
         chk(d == 0 ? "ram_final_be" : "ram_final_le", 32'(bad), 32'd0);
      end

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
